// File: rtl/regfile_sb_if.sv
// Register-file/scoreboard bus: read ports, write ports, issue handshake, flush and busy count.
// The master is the pipeline side; the slave is the register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 2
);
  logic [NREAD*ADDR_W-1:0]  raddr;
  logic [NREAD*DATA_W-1:0]  rdata;
  logic [NREAD-1:0]         rbusy;
  logic [NWRITE-1:0]        we;
  logic [NWRITE*ADDR_W-1:0] waddr;
  logic [NWRITE*DATA_W-1:0] wdata;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output raddr, we, waddr, wdata, iss_valid, iss_addr, flush,
    input  rdata, rbusy, iss_ready, busy_cnt
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_valid, iss_addr, flush,
    output rdata, rbusy, iss_ready, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass, fixed write-port priority and a per-register
// busy scoreboard with an outstanding-writer counter.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 2
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]             r_rf [DEPTH];
  logic [DEPTH-1:0]              r_busy;
  logic [ADDR_W:0]               r_cnt;

  logic [DEPTH-1:0]              w_clr;
  logic [DEPTH-1:0][DATA_W-1:0]  w_wr_data;
  logic [DEPTH-1:0]              w_iss_mask;
  logic [DEPTH-1:0]              w_busy_d;
  logic                          w_iss_ready;
  logic                          w_iss_acc;
  logic [ADDR_W:0]               w_nclr;
  logic [ADDR_W:0]               w_cnt_d;

  // Later ports overwrite earlier ones, giving the highest index priority.
  always_comb begin
    w_clr     = '0;
    w_wr_data = '0;
    for (int j = 0; j < int'(NWRITE); j++) begin
      if (bus.we[j] && bus.waddr[j*ADDR_W +: ADDR_W] != '0) begin
        w_clr[bus.waddr[j*ADDR_W +: ADDR_W]]     = 1'b1;
        w_wr_data[bus.waddr[j*ADDR_W +: ADDR_W]] = bus.wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  assign w_iss_ready = ~bus.flush & ~r_busy[bus.iss_addr];
  assign w_iss_acc   = bus.iss_valid & w_iss_ready & (bus.iss_addr != '0);

  always_comb begin
    w_iss_mask = '0;
    if (w_iss_acc) begin
      w_iss_mask[bus.iss_addr] = 1'b1;
    end
  end

  // Only registers that were busy and are not re-claimed by this cycle's issue count down.
  always_comb begin
    w_nclr = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_nclr = w_nclr + {{ADDR_W{1'b0}}, r_busy[k] & w_clr[k] & ~w_iss_mask[k]};
    end
  end

  always_comb begin
    w_busy_d = '0;
    w_cnt_d  = '0;
    if (!bus.flush) begin
      w_busy_d = (r_busy & ~w_clr) | w_iss_mask;
      w_cnt_d  = r_cnt + {{ADDR_W{1'b0}}, w_iss_acc} - w_nclr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_rf[k] <= '0;
      end
    end else begin
      r_busy <= w_busy_d;
      r_cnt  <= w_cnt_d;
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (w_clr[k]) begin
          r_rf[k] <= w_wr_data[k];
        end
      end
    end
  end

  for (genvar gi = 0; gi < int'(NREAD); gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = bus.raddr[gi*ADDR_W +: ADDR_W];
    assign bus.rdata[gi*DATA_W +: DATA_W] = (w_ra == '0) ? '0 :
                                            w_clr[w_ra]   ? w_wr_data[w_ra] : r_rf[w_ra];
    assign bus.rbusy[gi] = r_busy[w_ra] & ~w_clr[w_ra];
  end

  assign bus.iss_ready = w_iss_ready;
  assign bus.busy_cnt  = r_cnt;
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general register file with a per-register scoreboard, for the decode/issue and writeback stages of the CPU pipeline. It provides NREAD combinational read ports with same-cycle write bypass and NWRITE write ports with fixed priority. A busy bit per register tracks pending writers: it is set at issue, cleared at writeback, and cleared in bulk by flush. An outstanding-writer counter is exported for drain and stall logic.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W registers
- NREAD, 2, number of read ports (≥1)
- NWRITE, 2, number of write ports (≥1); higher index has priority

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- raddr  in  NREAD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rbusy  out  NREAD  register at raddr[i] still has a pending writer
- we  in  NWRITE  write enables
- waddr  in  NWRITE*ADDR_W  write addresses
- wdata  in  NWRITE*DATA_W  write data
- iss_valid  in  1  request to mark iss_addr pending
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- iss_ready  out  1  issue can be accepted this cycle
- flush  in  1  clear all busy bits; no data change
- busy_cnt  out  ADDR_W+1  number of busy registers

## Operation
- **Storage:** rf[DEPTH] of DATA_W bits, busy[DEPTH], cnt.
- **Register 0:**
  - Reads return 0; rbusy returns 0.
  - Writes and issues to 0 are ignored; an issue to 0 is accepted with no busy effect.
- **Write:**
  - On posedge, each port j with we[j] and waddr[j]≠0 writes rf[waddr[j]] ← wdata[j].
  - Same address on several ports: the highest-index port's data is stored.
- **Write clear:** a write clears busy[waddr] (the "clear set", deduplicated across ports). Writes to non-busy registers are legal; they update data only.
- **Read bypass** (combinational):
  - rdata[i] = wdata of the highest-index port j with we[j] and waddr[j]==raddr[i]≠0; otherwise rf[raddr[i]].
  - rbusy[i] = busy[raddr[i]] and not in this cycle's clear set.
- **Issue handshake:**
  - iss_ready = ~flush & ~busy[iss_addr]. Ready is not bypassed: a same-cycle writeback to a busy iss_addr does not raise ready.
  - Accept = iss_valid & iss_ready. On accept with iss_addr≠0, busy[iss_addr] ← 1 at posedge.
- **Simultaneous issue and write to the same non-busy address:** data is written and busy ends set (issue wins).
- **Flush:** at posedge, all busy ← 0 and cnt ← 0. No issue is accepted in a flush cycle. Writes in that cycle still update data.
- **Counter:** cnt_next = cnt + (accepted issue to a non-zero register) − (number of distinct busy registers in the clear set, excluding the issue address when issue wins). busy_cnt = cnt, and always equals popcount(busy).
- **Reset** (async, any time, including mid-operation): all rf = 0, all busy = 0, cnt = 0.
  - Outputs immediately: rdata = bypass value or 0, rbusy = 0, busy_cnt = 0, iss_ready = ~flush.

## Timing
- **Combinational paths:** rdata, rbusy and iss_ready are combinational from the inputs and current state, so read latency is 0 cycles.
- **Write visibility:** a write at edge N is visible through bypass in the same cycle and from the array from cycle N+1.
- **Busy timing:** a busy bit set by an accepted issue at edge N shows on rbusy and blocks iss_ready from cycle N+1.
- **Clear timing:** a clear is visible on rbusy combinationally in the write cycle; busy_cnt updates after the edge.
- **Flush duration:** single cycle. busy_cnt = 0 in the cycle after flush.

## Test plan
- **Reset:** assert reset mid-stream with busy_cnt=3 → asynchronously busy_cnt=0, all rbusy=0; reading r5 returns 0.
- **Bypass and priority:**
  - we=2'b11, waddr0=waddr1=7, wdata0=0x11111111, wdata1=0x22222222, raddr0=7 → rdata0=0x22222222 in the same cycle.
  - Next cycle with we=0 → rdata0=0x22222222 from the array.
- **Register 0:** write r0=0xDEADBEEF, issue r0 → rdata=0, rbusy=0, busy_cnt unchanged, iss_ready=1.
- **Scoreboard:**
  - Issue r3 → next cycle rbusy=1, iss_ready=0 for r3, busy_cnt=1.
  - Write r3=0x5 → rbusy=0 in the same cycle; busy_cnt=0 next cycle.
- **Simultaneous events:**
  - Issue r4 with port0 writing r4=0x9 (r4 not busy) → r4=0x9, busy[r4]=1, busy_cnt=1.
  - Both ports write busy r6 → busy_cnt decrements by exactly 1.
- **Flush:** busy r1, r2, r9 plus iss_valid for r10 with flush=1 → iss_ready=0; next cycle busy_cnt=0, all rbusy=0, r10 not busy.
